// File: rtl/cache_pkg.sv
// Shared types and address helpers for the 4-way set-associative cache controller.
package cache_pkg;

  localparam int WAYS  = 4;
  localparam int WAY_W = 2;
  localparam int AGE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WRITEBACK,
    ST_REFILL,
    ST_RESPOND
  } ctrl_state_t;

  // Set index of a byte address, right-aligned; callers cast to SET_BITS.
  function automatic logic [31:0] addr_set(input logic [31:0] addr, input int unsigned set_bits);
    return (addr >> 2) & ((32'd1 << set_bits) - 32'd1);
  endfunction

  // Tag of a byte address, right-aligned; callers cast to TAG_BITS.
  function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int unsigned set_bits);
    return addr >> (set_bits + 2);
  endfunction

endpackage

// File: rtl/cache_controller_lru.sv
// Per-set replacement logic: victim choice from valid bits and ages, and the
// age vector that results from touching one way.
module cache_lru
  import cache_pkg::*;
(
  input  logic [WAYS-1:0]             valid_i,
  input  logic [WAYS-1:0][AGE_W-1:0]  ages_i,
  input  logic [WAY_W-1:0]            access_way_i,
  output logic [WAY_W-1:0]            victim_way_o,
  output logic [WAYS-1:0][AGE_W-1:0]  ages_o
);

  logic any_invalid;

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    victim_way_o = '0;
    any_invalid  = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_i[w]) begin
        victim_way_o = WAY_W'(w);
        any_invalid  = 1'b1;
      end
    end
    if (!any_invalid) begin
      for (int w = 0; w < WAYS; w++) begin
        if (ages_i[w] == AGE_W'(WAYS - 1)) victim_way_o = WAY_W'(w);
      end
    end
  end

  // Touched way becomes youngest; only ways younger than it age by one.
  always_comb begin
    ages_o = ages_i;
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == access_way_i) begin
        ages_o[w] = '0;
      end else if (ages_i[w] < ages_i[access_way_i]) begin
        ages_o[w] = ages_i[w] + AGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/cache_controller.sv
// Write-back, write-allocate sequencing controller for a 4-way set-associative
// one-word-per-line data cache with a valid/ack main-memory port.
module cache_controller
  import cache_pkg::*;
#(
  parameter  int SET_BITS   = 4,
  parameter  int DATA_WIDTH = 32,
  localparam int TAG_BITS   = 32 - SET_BITS - 2,
  localparam int NUM_SETS   = 1 << SET_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [31:0]           cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic                  cpu_ready_o,
  output logic                  cpu_done_o,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  output logic                  cpu_hit_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [31:0]           mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ack_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  ctrl_state_t           state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  hit_q, hit_d;
  logic [WAY_W-1:0]      victim_q, victim_d;
  logic                  mem_req_q, mem_req_d;

  logic [TAG_BITS-1:0]            tag_q   [NUM_SETS][WAYS];
  logic [DATA_WIDTH-1:0]          data_q  [NUM_SETS][WAYS];
  logic [WAYS-1:0]                valid_q [NUM_SETS];
  logic [WAYS-1:0]                dirty_q [NUM_SETS];
  logic [WAYS-1:0][AGE_W-1:0]     age_q   [NUM_SETS];

  logic [SET_BITS-1:0]        lk_set;
  logic [TAG_BITS-1:0]        lk_tag;
  logic                       hit_any;
  logic [WAY_W-1:0]           hit_way;
  logic [WAY_W-1:0]           lru_victim;
  logic [WAYS-1:0][AGE_W-1:0] lru_ages;

  logic                  wr_en, wr_dirty, touch;
  logic [WAY_W-1:0]      acc_way;
  logic [DATA_WIDTH-1:0] wr_data;

  assign lk_set = SET_BITS'(addr_set(addr_q, SET_BITS));
  assign lk_tag = TAG_BITS'(addr_tag(addr_q, SET_BITS));

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[lk_set][w] && tag_q[lk_set][w] == lk_tag) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  cache_lru u_lru (
    .valid_i      (valid_q[lk_set]),
    .ages_i       (age_q[lk_set]),
    .access_way_i (acc_way),
    .victim_way_o (lru_victim),
    .ages_o       (lru_ages)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    hit_d     = hit_q;
    victim_d  = victim_q;
    mem_req_d = mem_req_q;
    wr_en     = 1'b0;
    wr_dirty  = 1'b0;
    wr_data   = wdata_q;
    touch     = 1'b0;
    acc_way   = victim_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req_i) begin
          addr_d  = cpu_addr_i;
          we_d    = cpu_we_i;
          wdata_d = cpu_wdata_i;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        hit_d    = hit_any;
        rdata_d  = '0;
        victim_d = lru_victim;
        acc_way  = hit_any ? hit_way : lru_victim;
        if (hit_any) begin
          touch    = 1'b1;
          wr_en    = we_q;
          wr_dirty = 1'b1;
          if (!we_q) rdata_d = data_q[lk_set][hit_way];
          state_d = ST_RESPOND;
        end else if (valid_q[lk_set][lru_victim] && dirty_q[lk_set][lru_victim]) begin
          mem_req_d = 1'b1;
          state_d   = ST_WRITEBACK;
        end else if (we_q) begin
          touch    = 1'b1;
          wr_en    = 1'b1;
          wr_dirty = 1'b1;
          state_d  = ST_RESPOND;
        end else begin
          mem_req_d = 1'b1;
          state_d   = ST_REFILL;
        end
      end
      ST_WRITEBACK: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          if (we_q) begin
            touch    = 1'b1;
            wr_en    = 1'b1;
            wr_dirty = 1'b1;
            state_d  = ST_RESPOND;
          end else begin
            state_d = ST_REFILL;
          end
        end
      end
      ST_REFILL: begin
        // After a writeback the request drops for one cycle before the read.
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (mem_ack_i) begin
          mem_req_d = 1'b0;
          touch     = 1'b1;
          wr_en     = 1'b1;
          wr_data   = mem_rdata_i;
          rdata_d   = mem_rdata_i;
          state_d   = ST_RESPOND;
        end
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      hit_q     <= 1'b0;
      victim_q  <= '0;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      hit_q     <= hit_d;
      victim_q  <= victim_d;
      mem_req_q <= mem_req_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AGE_W'(w);
      end
    end else begin
      if (wr_en) begin
        valid_q[lk_set][acc_way] <= 1'b1;
        dirty_q[lk_set][acc_way] <= wr_dirty;
      end
      if (touch) age_q[lk_set] <= lru_ages;
    end
  end

  // NOTE: tag and data storage is not reset; valid bits alone qualify its contents.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tag_q[lk_set][acc_way]  <= lk_tag;
      data_q[lk_set][acc_way] <= wr_data;
    end
  end

  assign cpu_ready_o = (state_q == ST_IDLE);
  assign cpu_done_o  = (state_q == ST_RESPOND);
  assign cpu_rdata_o = cpu_done_o ? rdata_q : '0;
  assign cpu_hit_o   = cpu_done_o & hit_q;

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_req_q && (state_q == ST_WRITEBACK);
  assign mem_wdata_o = mem_we_o ? data_q[lk_set][victim_q] : '0;
  always_comb begin
    mem_addr_o = '0;
    if (mem_we_o)       mem_addr_o = {tag_q[lk_set][victim_q], lk_set, 2'b00};
    else if (mem_req_q) mem_addr_o = {lk_tag, lk_set, 2'b00};
  end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed scenarios plus random traffic
// compared against a recency-list cache model and a sparse main-memory model.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cpu_req_i, cpu_we_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i;
  logic        cpu_ready_o, cpu_done_o, cpu_hit_o;
  logic [31:0] cpu_rdata_o;
  logic        mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  always #5 clk = ~clk;

  cache_controller #(.SET_BITS(4), .DATA_WIDTH(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_ready_o (cpu_ready_o),
    .cpu_done_o  (cpu_done_o),
    .cpu_rdata_o (cpu_rdata_o),
    .cpu_hit_o   (cpu_hit_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] last_wb_addr, last_rf_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: per set, four lines plus a recency list (front = most recent).
  bit          m_valid [16][4];
  bit          m_dirty [16][4];
  logic [31:0] m_tag   [16][4];
  logic [31:0] m_data  [16][4];
  int          m_order [16][$];
  logic [31:0] mem_model [logic [31:0]];

  function automatic void model_reset();
    for (int s = 0; s < 16; s++) begin
      m_order[s].delete();
      for (int w = 0; w < 4; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_order[s].push_back(w);
      end
    end
  endfunction

  function automatic void model_touch(input int s, input int w);
    for (int i = 0; i < m_order[s].size(); i++) begin
      if (m_order[s][i] == w) begin
        m_order[s].delete(i);
        break;
      end
    end
    m_order[s].push_front(w);
  endfunction

  task automatic model_access(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                              output bit hit, output logic [31:0] rdata,
                              output bit wb, output logic [31:0] wb_addr, output logic [31:0] wb_data,
                              output bit rf, output logic [31:0] rf_addr);
    int s = int'((addr >> 2) & 32'hF);
    logic [31:0] t = addr >> 6;
    int w = -1;
    hit = 1'b0; rdata = '0; wb = 1'b0; wb_addr = '0; wb_data = '0; rf = 1'b0; rf_addr = '0;
    for (int i = 0; i < 4; i++) begin
      if (m_valid[s][i] && m_tag[s][i] == t) begin
        w = i;
        hit = 1'b1;
      end
    end
    if (!hit) begin
      for (int i = 3; i >= 0; i--) if (!m_valid[s][i]) w = i;
      if (w < 0) w = m_order[s][3];
      if (m_valid[s][w] && m_dirty[s][w]) begin
        wb      = 1'b1;
        wb_addr = (m_tag[s][w] << 6) | (32'(s) << 2);
        wb_data = m_data[s][w];
        mem_model[wb_addr] = wb_data;
      end
      m_valid[s][w] = 1'b1;
      m_dirty[s][w] = 1'b0;
      m_tag[s][w]   = t;
      if (!we) begin
        rf      = 1'b1;
        rf_addr = addr & ~32'h3;
        if (!mem_model.exists(rf_addr)) mem_model[rf_addr] = $urandom;
        m_data[s][w] = mem_model[rf_addr];
      end
    end
    if (we) begin
      m_data[s][w]  = wd;
      m_dirty[s][w] = 1'b1;
    end else begin
      rdata = m_data[s][w];
    end
    model_touch(s, w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    cpu_req_i = 1'b0;
    mem_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    model_reset();
  endtask

  // One CPU access with a responding memory; noise drives cpu_req_i while busy.
  task automatic do_access(input bit we, input logic [31:0] addr, input logic [31:0] wd, input bit noise);
    bit e_hit, e_wb, e_rf;
    logic [31:0] e_rd, e_wba, e_wbd, e_rfa, exp_addr;
    int cyc, wait_left;
    bit done_seen, wb_pend, rf_pend, in_req, cur_wb;
    model_access(we, addr, wd, e_hit, e_rd, e_wb, e_wba, e_wbd, e_rf, e_rfa);
    wb_pend = e_wb; rf_pend = e_rf; in_req = 1'b0; cur_wb = 1'b0;
    done_seen = 1'b0; cyc = 0; wait_left = 0; exp_addr = '0;
    @(negedge clk);
    while (!cpu_ready_o && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("ready_before_req", 32'(cpu_ready_o), 32'd1);
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd;
    @(negedge clk);
    cpu_req_i = 1'b0;
    cyc = 1;
    while (!done_seen && cyc < 100) begin
      check("ready_low_busy", 32'(cpu_ready_o), 32'd0);
      if (noise && !cpu_done_o) begin
        cpu_req_i = 1'b1; cpu_we_i = 1'($urandom); cpu_addr_i = $urandom; cpu_wdata_i = $urandom;
      end
      if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        in_req = 1'b0;
        check("mem_req_drop", 32'(mem_req_o), 32'd0);
      end else if (mem_req_o) begin
        if (!in_req) begin
          in_req = 1'b1;
          wait_left = int'($urandom_range(0, 3));
          cur_wb = wb_pend;
          if (wb_pend)      exp_addr = e_wba;
          else if (rf_pend) exp_addr = e_rfa;
          else              check("unexpected_mem_req", 32'(mem_req_o), 32'd0);
          if (cur_wb) begin
            check("wb_wdata", mem_wdata_o, e_wbd);
            last_wb_addr = mem_addr_o;
          end else begin
            last_rf_addr = mem_addr_o;
          end
        end
        check("mem_we", 32'(mem_we_o), 32'(cur_wb));
        check("mem_addr", mem_addr_o, exp_addr);
        if (wait_left == 0) begin
          mem_ack_i = 1'b1;
          mem_rdata_i = (!cur_wb && mem_model.exists(exp_addr)) ? mem_model[exp_addr] : $urandom;
          if (cur_wb) wb_pend = 1'b0;
          else        rf_pend = 1'b0;
        end else begin
          wait_left--;
        end
      end
      if (cpu_done_o) begin
        done_seen = 1'b1;
        cpu_req_i = 1'b0;
        check("cpu_hit", 32'(cpu_hit_o), 32'(e_hit));
        check("cpu_rdata", cpu_rdata_o, e_rd);
        check("mem_phases_left", {30'd0, wb_pend, rf_pend}, 32'd0);
        if (!e_wb && !e_rf) check("latency", 32'(cyc), 32'd2);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("done_seen", 32'(done_seen), 32'd1);
    cpu_req_i = 1'b0;
    mem_ack_i = 1'b0;
    @(negedge clk);
    check("done_pulse_end", 32'(cpu_done_o), 32'd0);
    check("rdata_idle", cpu_rdata_o, 32'd0);
    check("ready_after", 32'(cpu_ready_o), 32'd1);
  endtask

  initial begin
    rst_i = 1'b1; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0; last_wb_addr = '0; last_rf_addr = '0;

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_ready", 32'(cpu_ready_o), 32'd1);
    check("rst_done", 32'(cpu_done_o), 32'd0);
    check("rst_rdata", cpu_rdata_o, 32'd0);
    check("rst_hit", 32'(cpu_hit_o), 32'd0);
    check("rst_mem_req", 32'(mem_req_o), 32'd0);
    check("rst_mem_we", 32'(mem_we_o), 32'd0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_wdata", mem_wdata_o, 32'd0);

    // Load miss refill, then hit
    mem_model[32'h40] = 32'hDEADBEEF;
    do_access(1'b0, 32'h40, '0, 1'b0);
    check("t1_rf_addr", last_rf_addr, 32'h40);
    do_access(1'b0, 32'h40, '0, 1'b0);

    // Store miss to an invalid way needs no memory
    do_reset();
    do_access(1'b1, 32'h80, 32'h11, 1'b0);
    do_access(1'b0, 32'h80, '0, 1'b0);

    // Dirty LRU victim is written back before the refill
    do_reset();
    do_access(1'b1, 32'h40,  32'hA0A0_0040, 1'b0);
    do_access(1'b1, 32'h80,  32'hA0A0_0080, 1'b0);
    do_access(1'b1, 32'hC0,  32'hA0A0_00C0, 1'b0);
    do_access(1'b1, 32'h100, 32'hA0A0_0100, 1'b0);
    do_access(1'b0, 32'h40,  '0, 1'b0);
    do_access(1'b0, 32'h140, '0, 1'b0);
    check("t3_wb_addr", last_wb_addr, 32'h80);
    check("t3_rf_addr", last_rf_addr, 32'h140);

    // Clean victim: refill only, oldest line evicted
    do_reset();
    do_access(1'b0, 32'h44,  '0, 1'b0);
    do_access(1'b0, 32'h84,  '0, 1'b0);
    do_access(1'b0, 32'hC4,  '0, 1'b0);
    do_access(1'b0, 32'h104, '0, 1'b0);
    last_wb_addr = '0;
    do_access(1'b0, 32'h144, '0, 1'b0);
    check("t4_no_wb", last_wb_addr, 32'h0);
    do_access(1'b0, 32'h84,  '0, 1'b0);
    do_access(1'b0, 32'h44,  '0, 1'b0);

    // Stalled refill, then reset mid-transaction
    do_reset();
    do_access(1'b1, 32'h40, 32'h55, 1'b0);
    @(negedge clk);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h240;
    @(negedge clk);
    cpu_req_i = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("stall_req", 32'(mem_req_o), 32'd1);
      check("stall_we", 32'(mem_we_o), 32'd0);
      check("stall_addr", mem_addr_o, 32'h240);
      if (i < 2) @(negedge clk);
    end
    rst_i = 1'b1;
    @(negedge clk);
    check("abort_mem_req", 32'(mem_req_o), 32'd0);
    check("abort_ready", 32'(cpu_ready_o), 32'd1);
    check("abort_done", 32'(cpu_done_o), 32'd0);
    rst_i = 1'b0;
    model_reset();
    do_access(1'b0, 32'h40, '0, 1'b0);

    // Requests while busy are ignored
    do_reset();
    do_access(1'b0, 32'h300, '0, 1'b1);
    do_access(1'b1, 32'h304, 32'h1234_5678, 1'b1);
    do_access(1'b0, 32'h300, '0, 1'b0);
    do_access(1'b0, 32'h304, '0, 1'b0);

    // Random traffic over a few conflicting tags in four sets
    do_reset();
    repeat (300) begin
      logic [31:0] a;
      a = ($urandom_range(0, 5) << 6) | ($urandom_range(0, 3) << 2);
      do_access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 7) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
Sequencing controller for the 4-way set-associative, one-word-per-line data cache. Accepts one CPU load/store at a time and owns the tag, valid, dirty, LRU and data arrays. Resolves hits locally; on a miss it selects an LRU victim, writes it back if dirty, then refills from main memory over a valid/ack handshake. Policy is write-back, write-allocate.

Parameters:
SET_BITS, 4, set index width; 2**SET_BITS sets; set = addr[SET_BITS+1:2]
DATA_WIDTH, 32, data word width
TAG_BITS, 32-SET_BITS-2 (26), tag = addr[31:SET_BITS+2]
WAYS is fixed at 4 (2-bit way index and ages); not a parameter

Ports:
clk_i  in  1  clock; all state updates on posedge
rst_i  in  1  reset; synchronous, active-high
cpu_req_i  in  1  request valid; accepted when cpu_req_i & cpu_ready_o
cpu_we_i  in  1  1 = store, 0 = load
cpu_addr_i  in  32  byte address; bits [1:0] ignored
cpu_wdata_i  in  DATA_WIDTH  store data
cpu_ready_o  out  1  high only in IDLE
cpu_done_o  out  1  one-cycle completion pulse
cpu_rdata_o  out  DATA_WIDTH  load data; valid while cpu_done_o=1, 0 otherwise
cpu_hit_o  out  1  qualifies cpu_done_o: 1 = request hit
mem_req_o  out  1  memory request valid
mem_we_o  out  1  1 = writeback, 0 = refill read
mem_addr_o  out  32  word address, bits [1:0]=0
mem_wdata_o  out  DATA_WIDTH  writeback data
mem_ack_i  in  1  memory accepted/completed; mem_rdata_i valid same cycle on reads
mem_rdata_i  in  DATA_WIDTH  refill data

Behaviour:
- Reset (sync, wins over everything): state=IDLE; all valid=0, dirty=0; way w age=w in every set; outputs cpu_ready_o=1, cpu_done_o=0, cpu_rdata_o=0, cpu_hit_o=0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
- Reset mid-transaction: request aborted, no done pulse, no writeback; dirty data is lost.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- IDLE: on accept, register addr/we/wdata -> LOOKUP.
- LOOKUP: compare tag against all valid ways (at most one match).
  - Hit: store writes data and sets dirty=1; load reads data. Update LRU -> RESPOND.
  - Miss: victim = lowest-index invalid way, else the way with age==3.
  - Miss, victim valid & dirty -> WRITEBACK.
  - Miss, store otherwise: install tag, data, valid=1, dirty=1; update LRU -> RESPOND (no memory read).
  - Miss, load otherwise -> REFILL.
- WRITEBACK: mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, set, 2'b00}, mem_wdata_o=victim data. Held stable until mem_ack_i. On ack: load -> REFILL; store -> install as above -> RESPOND.
- REFILL: mem_req_o=1, mem_we_o=0, mem_addr_o={tag, set, 2'b00}, held stable until mem_ack_i. On ack: install mem_rdata_i, valid=1, dirty=0, update LRU, capture data for response -> RESPOND.
- mem_req_o deasserts the cycle after ack. Back-to-back writeback then refill has one idle cycle between them.
- RESPOND: cpu_done_o=1 for one cycle; cpu_rdata_o=load data (0 for stores); cpu_hit_o=hit flag -> IDLE.
- Latency: hit, or store miss to a clean/invalid way, gives cpu_done_o 2 cycles after accept. Misses add memory wait cycles.
- LRU update for access to way a in set s: every way with age < age[a] increments; age[a]=0. Ages remain a permutation of 0..3.
- cpu_req_i is ignored outside IDLE.

Decomposition:
- Package cache_pkg: state enum ctrl_state_t; WAYS=4; AGE_W=2; tag/set extraction helpers.
- One sub-module, cache_lru: combinational victim select (valid + ages) and next-age computation for one set.

Test Plan:
- Reset, load 0x0000_0040 -> REFILL, mem_addr_o=0x40, mem_we_o=0; ack with mem_rdata_i=0xDEADBEEF -> cpu_done_o, rdata=0xDEADBEEF, hit=0. Reload 0x40 -> done 2 cycles after accept, hit=1, no mem_req_o.
- Store 0x0000_0080 data 0x11 after reset -> no mem traffic, done in 2 cycles. Load 0x80 -> hit, rdata=0x11.
- Stores to 0x40, 0x80, 0xC0, 0x100 (set 0), then load 0x40, then load 0x140 -> writeback mem_we_o=1, addr 0x80, wdata = 0x80's data; then refill read at 0x140.
- Fill set 1 (0x44, 0x84, 0xC4, 0x104) by loads only, then load 0x144 -> refill only, no writeback. Victim is the 0x44 way.
- Hold mem_ack_i low 5 cycles during REFILL -> mem_req_o/mem_addr_o stable throughout; assert rst_i in cycle 3 -> next cycle mem_req_o=0, cpu_ready_o=1, no done. Later load 0x40 misses.
- Assert cpu_req_i while busy -> ignored; request counted only after cpu_ready_o returns.
